// File: rtl/dds_sweep_ctrl.sv
// Stepped-frequency sweep sequencer: walks the DDS phase increment through
// descriptor-defined linear segments, chaining descriptors without gaps.
module dds_sweep_ctrl #(
    parameter string HOLD_LAST = "TRUE"
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [95:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        stop,
    output logic [31:0] pinc,
    output logic        seg_start,
    output logic        seg_last,
    output logic        busy
);

    localparam bit HOLD_EN = (HOLD_LAST == "TRUE");

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_reg;
    logic [31:0] pinc_reg;
    logic [31:0] step_reg;
    logic [15:0] dcnt_reg;
    logic [15:0] scnt_reg;
    logic [15:0] d_reg;
    logic        seg_start_reg;

    logic        final_cycle;
    logic        handshake;
    logic [31:0] idle_pinc;

    // Final cycle of a segment: both counters exhausted while running.
    assign final_cycle   = (state_reg == RUN) && (dcnt_reg == 16'd0) && (scnt_reg == 16'd0);
    assign s_axis_tready = ((state_reg == IDLE) || final_cycle) && !stop && !areset;
    assign handshake     = s_axis_tvalid && s_axis_tready;
    assign idle_pinc     = HOLD_EN ? pinc_reg : 32'd0;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= IDLE;
            pinc_reg      <= 32'd0;
            step_reg      <= 32'd0;
            dcnt_reg      <= 16'd0;
            scnt_reg      <= 16'd0;
            d_reg         <= 16'd0;
            seg_start_reg <= 1'b0;
        end else begin
            seg_start_reg <= 1'b0;
            if (stop) begin
                state_reg <= IDLE;
                pinc_reg  <= idle_pinc;
            end else if (handshake) begin
                // Load from IDLE or chain straight out of a segment's final cycle.
                state_reg     <= RUN;
                pinc_reg      <= s_axis_tdata[31:0];
                step_reg      <= s_axis_tdata[63:32];
                scnt_reg      <= s_axis_tdata[79:64];
                dcnt_reg      <= s_axis_tdata[95:80];
                d_reg         <= s_axis_tdata[95:80];
                seg_start_reg <= 1'b1;
            end else if (state_reg == RUN) begin
                if (dcnt_reg != 16'd0) begin
                    dcnt_reg <= dcnt_reg - 16'd1;
                end else if (scnt_reg != 16'd0) begin
                    pinc_reg <= pinc_reg + step_reg;
                    scnt_reg <= scnt_reg - 16'd1;
                    dcnt_reg <= d_reg;
                end else begin
                    state_reg <= IDLE;
                    pinc_reg  <= idle_pinc;
                end
            end
        end
    end

    assign pinc      = pinc_reg;
    assign seg_start = seg_start_reg;
    assign seg_last  = final_cycle;
    assign busy      = (state_reg == RUN);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: one instance holds the last pinc, the
// other returns to zero; both see identical stimulus.
module tb_dds_sweep_ctrl;

    logic        aclk;
    logic        areset;
    logic [95:0] tdata;
    logic        tvalid;
    logic        stop;
    logic        rdy_a, rdy_b;
    logic [31:0] pinc_a, pinc_b;
    logic        ss_a, ss_b, sl_a, sl_b, busy_a, busy_b;

    dds_sweep_ctrl #(.HOLD_LAST("TRUE")) dut_a (
        .aclk(aclk), .areset(areset), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(rdy_a), .stop(stop), .pinc(pinc_a), .seg_start(ss_a),
        .seg_last(sl_a), .busy(busy_a)
    );

    dds_sweep_ctrl #(.HOLD_LAST("FALSE")) dut_b (
        .aclk(aclk), .areset(areset), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(rdy_b), .stop(stop), .pinc(pinc_b), .seg_start(ss_b),
        .seg_last(sl_b), .busy(busy_b)
    );

    typedef struct {
        int          cyc;
        logic [31:0] pa;
        logic [31:0] pb;
        logic        ss;
        logic        sl;
        logic        bz;
        logic        rd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [95:0] desc(logic [31:0] start, logic [31:0] step,
                                         logic [15:0] n, logic [15:0] d);
        return {d, n, step, start};
    endfunction

    function automatic void push(int c, logic [31:0] pa, logic [31:0] pb,
                                 logic ss, logic sl, logic bz, logic rd);
        exp_t e;
        e.cyc = c; e.pa = pa; e.pb = pb; e.ss = ss; e.sl = sl; e.bz = bz; e.rd = rd;
        q.push_back(e);
    endfunction

    // Basic sweep 0x0100_0000 + k*0x0010_0000, N=3, D=1: eight cycles from h.
    function automatic void push_basic(int h);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] p;
            p = 32'h0100_0000 + 32'(i / 2) * 32'h0010_0000;
            push(h + i, p, p, i == 0, i == 7, 1'b1, i == 7);
        end
    endfunction

    // Monitor: compares both instances on the cycle each expectation names.
    always @(negedge aclk) begin
        logic [71:0] act, expv;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_check cyc=%0d act=none req=expectation", q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            act  = {pinc_a, pinc_b, ss_a, sl_a, busy_a, rdy_a, ss_b, sl_b, busy_b, rdy_b};
            expv = {e.pa, e.pb, e.ss, e.sl, e.bz, e.rd, e.ss, e.sl, e.bz, e.rd};
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL cycle_check cyc=%0d act=%h req=%h (pa,pb,ss/sl/busy/rdy a,b)",
                         cyc, act, expv);
            end
        end
    end

    task automatic tick(output int now);
        @(posedge aclk);
        #1;
        now = cyc;
    endtask

    task automatic wait_n(int n);
        int t;
        for (int i = 0; i < n; i++) tick(t);
    endtask

    initial begin
        int now, h;
        areset = 1'b1; tvalid = 1'b0; stop = 1'b0; tdata = '0;

        // Reset state; tready forced low even with tvalid high.
        tick(now); tick(now);
        tvalid = 1'b1; tdata = desc(32'h0100_0000, 32'h0010_0000, 16'd3, 16'd1);
        push(now, 32'd0, 32'd0, 0, 0, 0, 0);
        $display("reset check at cycle %0d", now);

        // Basic sweep.
        tick(now);
        areset = 1'b0;
        push(now, 32'd0, 32'd0, 0, 0, 0, 1);
        tick(h);
        tvalid = 1'b0;
        $display("basic sweep loaded at cycle %0d", h);
        push_basic(h);
        push(h + 8, 32'h0130_0000, 32'd0, 0, 0, 0, 1);
        wait_n(9);

        // Gapless chain: second descriptor held valid through the first segment.
        tvalid = 1'b1; tdata = desc(32'h0100_0000, 32'h0010_0000, 16'd3, 16'd1);
        tick(h);
        tdata = desc(32'h8000_0000, 32'hFFFF_FF00, 16'd2, 16'd0);
        $display("chain first segment loaded at cycle %0d", h);
        push_basic(h);
        push(h + 8,  32'h8000_0000, 32'h8000_0000, 1, 0, 1, 0);
        push(h + 9,  32'h7FFF_FF00, 32'h7FFF_FF00, 0, 0, 1, 0);
        push(h + 10, 32'h7FFF_FE00, 32'h7FFF_FE00, 0, 1, 1, 1);
        push(h + 11, 32'h7FFF_FE00, 32'd0, 0, 0, 0, 1);
        wait_n(8);
        tvalid = 1'b0;
        $display("chain second segment started at cycle %0d", h + 8);
        wait_n(4);

        // Wrap-around, N=1 D=0.
        tvalid = 1'b1; tdata = desc(32'hFFFF_FFF0, 32'h0000_0020, 16'd1, 16'd0);
        tick(h);
        tvalid = 1'b0;
        $display("wrap segment loaded at cycle %0d", h);
        push(h,     32'hFFFF_FFF0, 32'hFFFF_FFF0, 1, 0, 1, 0);
        push(h + 1, 32'h0000_0010, 32'h0000_0010, 0, 1, 1, 1);
        push(h + 2, 32'h0000_0010, 32'd0, 0, 0, 0, 1);
        wait_n(3);

        // Single-cycle segment, N=0 D=0.
        tvalid = 1'b1; tdata = desc(32'h1234_5678, 32'h0000_0001, 16'd0, 16'd0);
        tick(h);
        tvalid = 1'b0;
        $display("single-cycle segment loaded at cycle %0d", h);
        push(h,     32'h1234_5678, 32'h1234_5678, 1, 1, 1, 1);
        push(h + 1, 32'h1234_5678, 32'd0, 0, 0, 0, 1);
        wait_n(2);

        // Stop mid-sweep with a descriptor pending.
        tvalid = 1'b1; tdata = desc(32'h0100_0000, 32'h0010_0000, 16'd3, 16'd1);
        tick(h);
        tvalid = 1'b0;
        $display("stop test sweep loaded at cycle %0d", h);
        push(h,     32'h0100_0000, 32'h0100_0000, 1, 0, 1, 0);
        push(h + 1, 32'h0100_0000, 32'h0100_0000, 0, 0, 1, 0);
        push(h + 2, 32'h0110_0000, 32'h0110_0000, 0, 0, 1, 0);
        push(h + 3, 32'h0110_0000, 32'd0, 0, 0, 0, 0);
        push(h + 4, 32'h0110_0000, 32'd0, 0, 0, 0, 1);
        push(h + 5, 32'h00AB_0000, 32'h00AB_0000, 1, 1, 1, 1);
        push(h + 6, 32'h00AB_0000, 32'd0, 0, 0, 0, 1);
        wait_n(2);
        stop = 1'b1; tvalid = 1'b1; tdata = desc(32'h00AB_0000, 32'h0000_0001, 16'd0, 16'd0);
        wait_n(2);
        stop = 1'b0;
        wait_n(1);
        tvalid = 1'b0;
        $display("stop test pending descriptor accepted after stop release");
        wait_n(2);

        // Reset mid-sweep, then a fresh descriptor.
        tvalid = 1'b1; tdata = desc(32'h0100_0000, 32'h0010_0000, 16'd3, 16'd1);
        tick(h);
        tvalid = 1'b0;
        $display("reset test sweep loaded at cycle %0d", h);
        push(h + 4, 32'h0120_0000, 32'h0120_0000, 0, 0, 1, 0);
        push(h + 5, 32'd0, 32'd0, 0, 0, 0, 0);
        push(h + 6, 32'd0, 32'd0, 0, 0, 0, 1);
        push(h + 7, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1, 0, 1, 0);
        push(h + 8, 32'h0000_0010, 32'h0000_0010, 0, 1, 1, 1);
        push(h + 9, 32'h0000_0010, 32'd0, 0, 0, 0, 1);
        wait_n(4);
        areset = 1'b1; tvalid = 1'b1;
        wait_n(2);
        areset = 1'b0; tdata = desc(32'hFFFF_FFF0, 32'h0000_0020, 16'd1, 16'd0);
        wait_n(1);
        tvalid = 1'b0;
        $display("reset test fresh descriptor issued");

        for (int i = 0; i < 50 && q.size() > 0; i++) wait_n(1);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain act=%0d pending req=0 pending", q.size());
        end
        wait_n(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

endmodule
